// File: rtl/wb_sdram_pkg.sv
// Shared definitions for the SDRAM Wishbone front end and the command
// controller: default address field widths, the row-bank-column address
// split, and the latency arithmetic both sides must agree on.
package wb_sdram_pkg;

    localparam int DEF_ROW_ADDR_BITS = 12;
    localparam int DEF_COL_ADDR_BITS = 9;
    localparam int DEF_BANK_SEL_BITS = 2;
    localparam int DEF_ADDR_BITS     = DEF_BANK_SEL_BITS + DEF_ROW_ADDR_BITS + DEF_COL_ADDR_BITS;

    // Word address layout, MSB first: row, bank, column.
    typedef struct packed {
        logic [DEF_ROW_ADDR_BITS-1:0] row;
        logic [DEF_BANK_SEL_BITS-1:0] bank;
        logic [DEF_COL_ADDR_BITS-1:0] col;
    } sdram_addr_t;

    // Tag carried alongside each in-flight transfer in the ack pipeline.
    typedef enum logic {
        ACK_WRITE = 1'b0,
        ACK_READ  = 1'b1
    } ack_kind_e;

    function automatic sdram_addr_t split_addr(input logic [DEF_ADDR_BITS-1:0] adr);
        return sdram_addr_t'(adr);
    endfunction

    // Accept-to-ack distance: one cycle for the controller to register the
    // command, CAS plus board delay until data is captured, one more to ack.
    function automatic int ack_lat(input int t_cl, input int rd_extra);
        return t_cl + rd_extra + 2;
    endfunction

    // Number of cycles after a read accept during which DQ may carry read data.
    function automatic int rd_busy_cycles(input int t_cl, input int rd_extra);
        return t_cl + rd_extra + 1;
    endfunction

endpackage

// File: rtl/sdram_ack_pipe.sv
// Fixed-depth valid/tag shift register that tracks in-flight transfers.
// Ports:
//   clk, sreset      clock and synchronous active-high reset
//   flush            synchronous clear of every valid bit
//   in_valid, in_tag entry pushed into stage 0 each cycle
//   tap_valid/tap_tag stage TAP, used to time the read-data capture
//   out_valid        last stage (DEPTH-1), i.e. the acknowledge
module sdram_ack_pipe #(
    parameter int DEPTH = 5,
    parameter int TAG_W = 1,
    parameter int TAP   = 3
) (
    input  logic             clk,
    input  logic             sreset,
    input  logic             flush,
    input  logic             in_valid,
    input  logic [TAG_W-1:0] in_tag,
    output logic             tap_valid,
    output logic [TAG_W-1:0] tap_tag,
    output logic             out_valid
);

    logic [DEPTH-1:0] valid_q;
    // Tags are only ever looked at up to the tap, so the tag chain stops there.
    logic [TAG_W-1:0] tag_q [TAP+1];

    always_ff @(posedge clk) begin
        if (sreset || flush) begin
            valid_q <= '0;
        end else begin
            valid_q <= {valid_q[DEPTH-2:0], in_valid};
        end
    end

    // Tags need no reset: they are qualified by the valid chain.
    always_ff @(posedge clk) begin
        tag_q[0] <= in_tag;
        for (int i = 1; i <= TAP; i++) begin
            tag_q[i] <= tag_q[i-1];
        end
    end

    assign tap_valid = valid_q[TAP];
    assign tap_tag   = tag_q[TAP];
    assign out_valid = valid_q[DEPTH-1];

endmodule

// File: rtl/wb_sdram_datapath.sv
// Wishbone B4 pipelined slave front end for the SDRAM command controller.
// Turns bus strobes into controller command handshakes, drives write data
// onto DQ the cycle the controller issues WRITE, captures read data after
// CAS latency and returns in-order acks at a fixed latency.
// Ports:
//   clk, sreset                      clock, synchronous active-high reset
//   wb_cyc/stb/we/adr/dat_w/sel      Wishbone request side
//   wb_stall/ack/dat_r               Wishbone response side
//   cmd_o_valid/ready/addr/we        command handshake to the controller
//   ram_dq_o/ram_dq_oe/ram_dq_i      SDRAM DQ pins owned by this block
module wb_sdram_datapath
    import wb_sdram_pkg::*;
#(
    parameter int ROW_ADDR_BITS = 12,
    parameter int COL_ADDR_BITS = 9,
    parameter int BANK_SEL_BITS = 2,
    parameter int DATA_BYTES    = 2,
    parameter int T_CL          = 3,
    parameter int RD_EXTRA      = 0,
    parameter int ADDR_BITS     = BANK_SEL_BITS + ROW_ADDR_BITS + COL_ADDR_BITS
) (
    input  logic                    clk,
    input  logic                    sreset,
    input  logic                    wb_cyc,
    input  logic                    wb_stb,
    input  logic                    wb_we,
    input  logic [ADDR_BITS-1:0]    wb_adr,
    input  logic [8*DATA_BYTES-1:0] wb_dat_w,
    input  logic [DATA_BYTES-1:0]   wb_sel,
    output logic                    wb_stall,
    output logic                    wb_ack,
    output logic [8*DATA_BYTES-1:0] wb_dat_r,
    output logic                    cmd_o_valid,
    input  logic                    cmd_o_ready,
    output logic [ADDR_BITS-1:0]    cmd_o_addr,
    output logic                    cmd_o_we,
    output logic [8*DATA_BYTES-1:0] ram_dq_o,
    output logic                    ram_dq_oe,
    input  logic [8*DATA_BYTES-1:0] ram_dq_i
);

    localparam int ACK_LAT   = ack_lat(T_CL, RD_EXTRA);
    localparam int BUSY_LOAD = rd_busy_cycles(T_CL, RD_EXTRA);
    localparam int CNT_W     = $clog2(BUSY_LOAD + 1);

    logic [CNT_W-1:0] busy_cnt;
    logic             rd_busy;
    logic             accept;
    logic             tap_valid;
    logic [0:0]       tap_tag;

    // A write must wait while read data may still be on DQ; reads never wait.
    assign rd_busy     = (busy_cnt != '0);
    assign cmd_o_valid = wb_cyc && wb_stb && !(wb_we && rd_busy);
    assign wb_stall    = !cmd_o_ready || (wb_we && rd_busy);
    assign accept      = cmd_o_valid && cmd_o_ready;
    assign cmd_o_addr  = wb_adr;
    assign cmd_o_we    = wb_we;

    always_ff @(posedge clk) begin
        if (sreset) begin
            busy_cnt <= '0;
        end else if (accept && !wb_we) begin
            busy_cnt <= CNT_W'(BUSY_LOAD);
        end else if (rd_busy) begin
            busy_cnt <= busy_cnt - 1'b1;
        end
    end

    // Write data goes out the cycle the controller has WRITE on the pins.
    // The data register holds between writes; only oe is pulsed.
    always_ff @(posedge clk) begin
        if (sreset) begin
            ram_dq_oe <= 1'b0;
            ram_dq_o  <= '0;
        end else begin
            ram_dq_oe <= accept && wb_we;
            if (accept && wb_we) begin
                ram_dq_o <= wb_dat_w;
            end
        end
    end

    // Dropping wb_cyc abandons everything in flight.
    sdram_ack_pipe #(
        .DEPTH (ACK_LAT),
        .TAG_W (1),
        .TAP   (ACK_LAT - 2)
    ) u_ack_pipe (
        .clk       (clk),
        .sreset    (sreset),
        .flush     (!wb_cyc),
        .in_valid  (accept),
        .in_tag    (!wb_we),
        .tap_valid (tap_valid),
        .tap_tag   (tap_tag),
        .out_valid (wb_ack)
    );

    // Read data is captured one cycle before its ack; skipped if the entry
    // is being flushed so wb_dat_r only ever changes on a real read ack.
    always_ff @(posedge clk) begin
        if (sreset) begin
            wb_dat_r <= '0;
        end else if (tap_valid && tap_tag[0] && wb_cyc) begin
            wb_dat_r <= ram_dq_i;
        end
    end

    // Partial byte writes are not supported; DQM is tied low downstream.
    sel_full_word: assert property (@(posedge clk) disable iff (sreset)
        (wb_cyc && wb_stb) |-> (wb_sel == '1));

endmodule

// File: tb/tb_wb_sdram_datapath.sv
// Self-checking bench for wb_sdram_datapath: directed scenarios plus a
// randomized run, all checked against a transaction-level model that keeps
// an SDRAM memory, a queue of due acks and a queue of DQ read returns.
module tb_wb_sdram_datapath;

    localparam int T_CL     = 3;
    localparam int RD_EXTRA = 0;
    localparam int ACK_LAT  = T_CL + RD_EXTRA + 2;
    localparam int BUSY_WIN = T_CL + RD_EXTRA + 1;
    localparam int AW       = 23;
    localparam int DW       = 16;

    logic          clk;
    logic          sreset;
    logic          wb_cyc, wb_stb, wb_we;
    logic [AW-1:0] wb_adr;
    logic [DW-1:0] wb_dat_w;
    logic [1:0]    wb_sel;
    logic          wb_stall, wb_ack;
    logic [DW-1:0] wb_dat_r;
    logic          cmd_o_valid, cmd_o_ready, cmd_o_we;
    logic [AW-1:0] cmd_o_addr;
    logic [DW-1:0] ram_dq_o, ram_dq_i;
    logic          ram_dq_oe;

    wb_sdram_datapath #(
        .ROW_ADDR_BITS (12),
        .COL_ADDR_BITS (9),
        .BANK_SEL_BITS (2),
        .DATA_BYTES    (2),
        .T_CL          (T_CL),
        .RD_EXTRA      (RD_EXTRA)
    ) dut (
        .clk         (clk),
        .sreset      (sreset),
        .wb_cyc      (wb_cyc),
        .wb_stb      (wb_stb),
        .wb_we       (wb_we),
        .wb_adr      (wb_adr),
        .wb_dat_w    (wb_dat_w),
        .wb_sel      (wb_sel),
        .wb_stall    (wb_stall),
        .wb_ack      (wb_ack),
        .wb_dat_r    (wb_dat_r),
        .cmd_o_valid (cmd_o_valid),
        .cmd_o_ready (cmd_o_ready),
        .cmd_o_addr  (cmd_o_addr),
        .cmd_o_we    (cmd_o_we),
        .ram_dq_o    (ram_dq_o),
        .ram_dq_oe   (ram_dq_oe),
        .ram_dq_i    (ram_dq_i)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc_n  = 0;

    typedef struct {
        int            due;
        bit            rd;
        logic [DW-1:0] dat;
    } ack_t;

    typedef struct {
        int            at;
        logic [DW-1:0] dat;
    } dq_t;

    ack_t          ackq[$];
    dq_t           dqq[$];
    logic [DW-1:0] mem [int];
    int            last_rd = -100;
    int            last_wr = -100;
    logic [DW-1:0] exp_dq_o = '0;
    logic [DW-1:0] exp_dat_r = '0;
    bit            exp_ack = 1'b0;
    bit            model_drive = 1'b0;

    // Reads accepted within the last BUSY_WIN cycles block writes.
    function automatic bit m_busy();
        return (cyc_n - last_rd) >= 1 && (cyc_n - last_rd) <= BUSY_WIN;
    endfunction

    function automatic bit m_accept();
        return wb_cyc && wb_stb && cmd_o_ready && !(wb_we && m_busy());
    endfunction

    function automatic bit m_stall();
        return !cmd_o_ready || (wb_we && m_busy());
    endfunction

    function automatic bit m_valid();
        return wb_cyc && wb_stb && !(wb_we && m_busy());
    endfunction

    function automatic bit m_oe();
        return last_wr == cyc_n - 1;
    endfunction

    function automatic logic [DW-1:0] mem_rd(input int a);
        if (!mem.exists(a)) mem[a] = DW'($urandom);
        return mem[a];
    endfunction

    task automatic set_bus(input bit c, input bit s, input bit w,
                           input logic [AW-1:0] a, input logic [DW-1:0] d);
        wb_cyc   = c;
        wb_stb   = s;
        wb_we    = w;
        wb_adr   = a;
        wb_dat_w = d;
    endtask

    // Advance one clock, updating the model with what the bus did this cycle,
    // then present SDRAM read data for the new cycle.
    task automatic tick();
        bit            acc, rst, cyc_l, we;
        logic [DW-1:0] d;
        int            a;
        ack_t          e;
        dq_t           q;
        acc   = m_accept();
        rst   = sreset;
        cyc_l = wb_cyc;
        we    = wb_we;
        a     = int'(wb_adr);
        d     = wb_dat_w;
        @(posedge clk);
        if (rst) begin
            ackq.delete();
            last_rd   = -100;
            last_wr   = -100;
            exp_dat_r = '0;
            exp_dq_o  = '0;
        end else begin
            if (!cyc_l) ackq.delete();
            if (acc) begin
                e.due = cyc_n + ACK_LAT;
                if (we) begin
                    mem[a]   = d;
                    last_wr  = cyc_n;
                    exp_dq_o = d;
                    e.rd     = 1'b0;
                    e.dat    = '0;
                end else begin
                    d       = mem_rd(a);
                    last_rd = cyc_n;
                    q.at    = cyc_n + 1 + T_CL + RD_EXTRA;
                    q.dat   = d;
                    dqq.push_back(q);
                    e.rd    = 1'b1;
                    e.dat   = d;
                end
                ackq.push_back(e);
            end
        end
        cyc_n++;
        #1;
        model_drive = 1'b0;
        ram_dq_i    = DW'($urandom);
        if (dqq.size() > 0 && dqq[0].at == cyc_n) begin
            ram_dq_i    = dqq[0].dat;
            model_drive = 1'b1;
            dqq.delete(0);
        end
        exp_ack = 1'b0;
        if (ackq.size() > 0 && ackq[0].due == cyc_n) begin
            exp_ack = 1'b1;
            if (ackq[0].rd) exp_dat_r = ackq[0].dat;
            ackq.delete(0);
        end
    endtask

    task automatic idle(input int n);
        set_bus(1, 0, 0, '0, '0);
        repeat (n) tick();
    endtask

    task automatic test_reset();
        sreset      = 1'b1;
        cmd_o_ready = 1'b1;
        set_bus(0, 0, 0, '0, '0);
        tick();
        tick();
        sreset = 1'b0;
        #1;
        checks++; if (wb_ack !== 1'b0) begin errors++; $display("FAIL rst_ack: got %b want 0", wb_ack); end
        checks++; if (wb_dat_r !== 16'h0) begin errors++; $display("FAIL rst_dat_r: got %h want 0000", wb_dat_r); end
        checks++; if (ram_dq_oe !== 1'b0) begin errors++; $display("FAIL rst_oe: got %b want 0", ram_dq_oe); end
        checks++; if (ram_dq_o !== 16'h0) begin errors++; $display("FAIL rst_dq_o: got %h want 0000", ram_dq_o); end
        checks++; if (wb_stall !== 1'b0) begin errors++; $display("FAIL rst_stall: got %b want 0", wb_stall); end
        checks++; if (cmd_o_valid !== 1'b0) begin errors++; $display("FAIL rst_valid: got %b want 0", cmd_o_valid); end
    endtask

    task automatic test_single_write();
        set_bus(1, 1, 1, 23'h10, 16'h0123);
        #1;
        checks++; if (wb_stall !== 1'b0) begin errors++; $display("FAIL wr_stall: got %b want 0", wb_stall); end
        checks++; if (cmd_o_valid !== 1'b1) begin errors++; $display("FAIL wr_valid: got %b want 1", cmd_o_valid); end
        checks++; if (cmd_o_addr !== 23'h10) begin errors++; $display("FAIL wr_addr: got %h want 000010", cmd_o_addr); end
        checks++; if (cmd_o_we !== 1'b1) begin errors++; $display("FAIL wr_we: got %b want 1", cmd_o_we); end
        for (int k = 1; k <= 7; k++) begin
            tick();
            set_bus(1, 0, 0, '0, '0);
            #1;
            checks++; if (ram_dq_oe !== (k == 1)) begin errors++; $display("FAIL wr_oe k=%0d: got %b want %b", k, ram_dq_oe, k == 1); end
            if (k == 1) begin
                checks++; if (ram_dq_o !== 16'h0123) begin errors++; $display("FAIL wr_dq_o: got %h want 0123", ram_dq_o); end
            end
            checks++; if (wb_ack !== (k == ACK_LAT)) begin errors++; $display("FAIL wr_ack k=%0d: got %b want %b", k, wb_ack, k == ACK_LAT); end
        end
    endtask

    task automatic test_single_read();
        mem[32'h20] = 16'hBEEF;
        set_bus(1, 1, 0, 23'h20, 16'h0);
        #1;
        checks++; if (cmd_o_valid !== 1'b1) begin errors++; $display("FAIL rd_valid: got %b want 1", cmd_o_valid); end
        for (int k = 1; k <= 7; k++) begin
            tick();
            set_bus(1, 0, 0, '0, '0);
            #1;
            checks++; if (wb_ack !== (k == ACK_LAT)) begin errors++; $display("FAIL rd_ack k=%0d: got %b want %b", k, wb_ack, k == ACK_LAT); end
            if (k >= ACK_LAT) begin
                checks++; if (wb_dat_r !== 16'hBEEF) begin errors++; $display("FAIL rd_data k=%0d: got %h want beef", k, wb_dat_r); end
            end
        end
    endtask

    task automatic test_turnaround();
        set_bus(1, 1, 0, 23'h10, 16'h0);
        for (int k = 1; k <= 11; k++) begin
            tick();
            if (k <= 5) set_bus(1, 1, 1, 23'h30, 16'h5A5A);
            else        set_bus(1, 0, 0, '0, '0);
            #1;
            if (k <= 5) begin
                checks++; if (wb_stall !== (k < 5)) begin errors++; $display("FAIL ta_stall k=%0d: got %b want %b", k, wb_stall, k < 5); end
                checks++; if (cmd_o_valid !== (k == 5)) begin errors++; $display("FAIL ta_valid k=%0d: got %b want %b", k, cmd_o_valid, k == 5); end
            end
            checks++; if (ram_dq_oe && model_drive) begin errors++; $display("FAIL ta_contention k=%0d: got oe=1 want 0 while read data on DQ", k); end
            checks++; if (ram_dq_oe !== (k == 6)) begin errors++; $display("FAIL ta_oe k=%0d: got %b want %b", k, ram_dq_oe, k == 6); end
            checks++; if (wb_ack !== (k == 5 || k == 10)) begin errors++; $display("FAIL ta_ack k=%0d: got %b want %b", k, wb_ack, k == 5 || k == 10); end
            if (k == 5) begin
                checks++; if (wb_dat_r !== 16'h0123) begin errors++; $display("FAIL ta_rd_data: got %h want 0123", wb_dat_r); end
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [DW-1:0] wd [4];
        for (int i = 0; i < 4; i++) wd[i] = DW'($urandom);
        for (int c = 0; c <= 14; c++) begin
            if (c < 8) set_bus(1, 1, c < 4, AW'(12'h100 + (c % 4)), wd[c % 4]);
            else       set_bus(1, 0, 0, '0, '0);
            #1;
            if (c < 8) begin
                checks++; if (wb_stall !== 1'b0) begin errors++; $display("FAIL b2b_stall c=%0d: got %b want 0", c, wb_stall); end
            end
            checks++; if (ram_dq_oe !== (c >= 1 && c <= 4)) begin errors++; $display("FAIL b2b_oe c=%0d: got %b want %b", c, ram_dq_oe, c >= 1 && c <= 4); end
            if (c >= 1 && c <= 4) begin
                checks++; if (ram_dq_o !== wd[c-1]) begin errors++; $display("FAIL b2b_dq_o c=%0d: got %h want %h", c, ram_dq_o, wd[c-1]); end
            end
            checks++; if (wb_ack !== (c >= 5 && c <= 12)) begin errors++; $display("FAIL b2b_ack c=%0d: got %b want %b", c, wb_ack, c >= 5 && c <= 12); end
            if (c >= 9 && c <= 12) begin
                checks++; if (wb_dat_r !== wd[c-9]) begin errors++; $display("FAIL b2b_rd_data c=%0d: got %h want %h", c, wb_dat_r, wd[c-9]); end
            end
            tick();
        end
    endtask

    task automatic test_cyc_drop();
        logic [DW-1:0] held;
        logic [DW-1:0] want;
        held = exp_dat_r;
        want = mem_rd(32'h102);
        for (int c = 0; c <= 9; c++) begin
            case (c)
                0:       set_bus(1, 1, 0, 23'h100, '0);
                1:       set_bus(1, 1, 0, 23'h101, '0);
                2:       set_bus(0, 0, 0, '0, '0);
                3:       set_bus(1, 1, 0, 23'h102, '0);
                default: set_bus(1, 0, 0, '0, '0);
            endcase
            #1;
            if (c >= 2) begin
                checks++; if (wb_ack !== (c == 8)) begin errors++; $display("FAIL drop_ack c=%0d: got %b want %b", c, wb_ack, c == 8); end
            end
            if (c == 7) begin
                checks++; if (wb_dat_r !== held) begin errors++; $display("FAIL drop_hold: got %h want %h", wb_dat_r, held); end
            end
            if (c == 8) begin
                checks++; if (wb_dat_r !== want) begin errors++; $display("FAIL drop_rd_data: got %h want %h", wb_dat_r, want); end
            end
            tick();
        end
    endtask

    task automatic test_ready_low();
        cmd_o_ready = 1'b0;
        set_bus(1, 1, 1, 23'h40, 16'hA5A5);
        for (int k = 0; k < 10; k++) begin
            #1;
            checks++; if (wb_stall !== 1'b1) begin errors++; $display("FAIL rdy_stall k=%0d: got %b want 1", k, wb_stall); end
            checks++; if (ram_dq_oe !== 1'b0) begin errors++; $display("FAIL rdy_oe k=%0d: got %b want 0", k, ram_dq_oe); end
            tick();
        end
        cmd_o_ready = 1'b1;
        #1;
        checks++; if (wb_stall !== 1'b0) begin errors++; $display("FAIL rdy_release: got %b want 0", wb_stall); end
        for (int k = 1; k <= 6; k++) begin
            tick();
            set_bus(1, 0, 0, '0, '0);
            #1;
            checks++; if (wb_ack !== (k == ACK_LAT)) begin errors++; $display("FAIL rdy_ack k=%0d: got %b want %b", k, wb_ack, k == ACK_LAT); end
            if (k == 1) begin
                checks++; if (ram_dq_o !== 16'hA5A5) begin errors++; $display("FAIL rdy_dq_o: got %h want a5a5", ram_dq_o); end
            end
        end
    endtask

    task automatic test_reset_mid();
        for (int c = 0; c <= 10; c++) begin
            sreset = (c == 2 || c == 4);
            case (c)
                0:       set_bus(1, 1, 0, 23'h40, '0);
                2, 3:    set_bus(1, 1, 1, 23'h50, 16'h1111);
                4:       set_bus(1, 1, 1, 23'h51, 16'h2222);
                default: set_bus(1, 0, 0, '0, '0);
            endcase
            #1;
            if (c == 2) begin
                checks++; if (cmd_o_valid !== 1'b0) begin errors++; $display("FAIL rmid_busy: got %b want 0", cmd_o_valid); end
            end
            if (c == 3) begin
                checks++; if (wb_stall !== 1'b0) begin errors++; $display("FAIL rmid_busy_cleared: got %b want 0", wb_stall); end
            end
            if (c >= 4 && c <= 5) begin
                checks++; if (ram_dq_oe !== (c == 4)) begin errors++; $display("FAIL rmid_oe c=%0d: got %b want %b", c, ram_dq_oe, c == 4); end
            end
            if (c >= 2) begin
                checks++; if (wb_ack !== 1'b0) begin errors++; $display("FAIL rmid_ack c=%0d: got %b want 0", c, wb_ack); end
            end
            if (c == 10) begin
                checks++; if (wb_dat_r !== 16'h0) begin errors++; $display("FAIL rmid_dat_r: got %h want 0000", wb_dat_r); end
            end
            tick();
        end
        sreset = 1'b0;
    endtask

    task automatic test_random();
        bit c, s, w;
        for (int n = 0; n < 420; n++) begin
            if (n < 400) begin
                c = ($urandom_range(0, 39) != 0);
                s = c && ($urandom_range(0, 9) < 7);
                w = $urandom_range(0, 1);
                cmd_o_ready = ($urandom_range(0, 9) < 8);
                set_bus(c, s, w, AW'(12'h200 + $urandom_range(0, 7)), DW'($urandom));
            end else begin
                cmd_o_ready = 1'b1;
                set_bus(1, 0, 0, '0, '0);
            end
            #1;
            checks++; if (wb_stall !== m_stall()) begin errors++; $display("FAIL rnd_stall n=%0d: got %b want %b", n, wb_stall, m_stall()); end
            checks++; if (cmd_o_valid !== m_valid()) begin errors++; $display("FAIL rnd_valid n=%0d: got %b want %b", n, cmd_o_valid, m_valid()); end
            checks++; if (wb_ack !== exp_ack) begin errors++; $display("FAIL rnd_ack n=%0d: got %b want %b", n, wb_ack, exp_ack); end
            checks++; if (wb_dat_r !== exp_dat_r) begin errors++; $display("FAIL rnd_dat_r n=%0d: got %h want %h", n, wb_dat_r, exp_dat_r); end
            checks++; if (ram_dq_oe !== m_oe()) begin errors++; $display("FAIL rnd_oe n=%0d: got %b want %b", n, ram_dq_oe, m_oe()); end
            if (m_oe()) begin
                checks++; if (ram_dq_o !== exp_dq_o) begin errors++; $display("FAIL rnd_dq_o n=%0d: got %h want %h", n, ram_dq_o, exp_dq_o); end
            end
            checks++; if (ram_dq_oe && model_drive) begin errors++; $display("FAIL rnd_contention n=%0d: got oe=1 want 0 while read data on DQ", n); end
            tick();
        end
    endtask

    initial begin
        sreset      = 1'b1;
        cmd_o_ready = 1'b1;
        wb_sel      = 2'b11;
        ram_dq_i    = '0;
        set_bus(0, 0, 0, '0, '0);
        test_reset();
        idle(2);
        test_single_write();
        idle(8);
        test_single_read();
        idle(8);
        test_turnaround();
        idle(8);
        test_back_to_back();
        idle(8);
        test_cyc_drop();
        idle(8);
        test_ready_low();
        idle(8);
        test_reset_mid();
        idle(8);
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        errors++;
        $display("FAIL watchdog: got no completion want finish within 1ms");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
